// File: rtl/ysyx_22040729_clint.sv
// Core-local interruptor: msip / mtimecmp / mtime behind a one-outstanding valid/ready bus.
// Optional mtime prescaler enabled by defining YSYX_22040729_CLINT_PRESCALE_EN (TICK_DIV cycles per tick).
module ysyx_22040729_clint #(
  parameter int DATA_WIDTH = 64,
  parameter int TICK_DIV   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wen,
  input  logic [15:0]             req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    tirp_o,
  output logic                    sirp_o
);

  typedef enum logic {
    S_IDLE,
    S_RESP
  } state_e;

  // Word indices (byte offset >> 3) of the mapped registers.
  localparam logic [12:0] MSIP_IDX     = 13'h0000;
  localparam logic [12:0] MTIMECMP_IDX = 13'h0800;
  localparam logic [12:0] MTIME_IDX    = 13'h17FF;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   mtime_q, mtime_d;
  logic [DATA_WIDTH-1:0]   mtimecmp_q, mtimecmp_d;
  logic                    msip_q, msip_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic                    accept;
  logic                    wr_en;
  logic [12:0]             word_idx;
  logic                    hit_msip, hit_mtimecmp, hit_mtime, mapped;
  logic [DATA_WIDTH-1:0]   rd_val;
  logic                    tick;
  logic                    mtime_wr;
  logic                    addr_unused;

  assign addr_unused = ^req_addr[2:0];

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0]   old_val,
    input logic [DATA_WIDTH-1:0]   new_val,
    input logic [DATA_WIDTH/8-1:0] strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_val;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

  assign word_idx     = req_addr[15:3];
  assign hit_msip     = (word_idx == MSIP_IDX);
  assign hit_mtimecmp = (word_idx == MTIMECMP_IDX);
  assign hit_mtime    = (word_idx == MTIME_IDX);
  assign mapped       = hit_msip | hit_mtimecmp | hit_mtime;

  assign accept   = req_valid && (state_q == S_IDLE);
  assign wr_en    = accept && req_wen;
  assign mtime_wr = wr_en && hit_mtime;

`ifdef YSYX_22040729_CLINT_PRESCALE_EN
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (mtime_wr || tick) presc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) presc_q <= '0;
    else      presc_q <= presc_d;
  end
`else
  localparam int tick_div_unused = TICK_DIV;

  assign tick = 1'b1;
`endif

  // Reads see the pre-edge register values, so a same-cycle tick is not visible.
  always_comb begin
    rd_val = '0;
    if (hit_msip)          rd_val = {{(DATA_WIDTH-1){1'b0}}, msip_q};
    else if (hit_mtimecmp) rd_val = mtimecmp_q;
    else if (hit_mtime)    rd_val = mtime_q;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RESP;
          rdata_d = req_wen ? '0 : rd_val;
          err_d   = !mapped;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (tick) mtime_d = mtime_q + DATA_WIDTH'(1);
    // A software write to mtime overrides the increment in the same cycle.
    if (mtime_wr) mtime_d = merge_bytes(mtime_q, req_wdata, req_wstrb);

    if (wr_en && hit_mtimecmp) mtimecmp_d = merge_bytes(mtimecmp_q, req_wdata, req_wstrb);
    if (wr_en && hit_msip && req_wstrb[0]) msip_d = req_wdata[0];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign tirp_o    = (mtime_q >= mtimecmp_q);
  assign sirp_o    = msip_q;

endmodule

// File: tb/tb_ysyx_22040729_clint.sv
// Scoreboard bench for ysyx_22040729_clint: expected responses queued at request time, checked at handshake.
// A cycle-level mtime model supplies expected mtime read values.
module tb_ysyx_22040729_clint;

  localparam int DW = 64;
`ifdef YSYX_22040729_CLINT_PRESCALE_EN
  localparam int TD = 4;
`else
  localparam int TD = 2;
`endif

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_wen;
  logic [15:0]   req_addr;
  logic [DW-1:0] req_wdata;
  logic [7:0]    req_wstrb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          tirp_o;
  logic          sirp_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW:0]   sb_q[$];
  logic [DW-1:0] m_mtime;
  int            m_presc;
  logic          post_tirp, post_sirp;

  ysyx_22040729_clint #(.DATA_WIDTH(DW), .TICK_DIV(TD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .tirp_o    (tirp_o),
    .sirp_o    (sirp_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [7:0] s);
    logic [DW-1:0] r;
    r = o;
    for (int b = 0; b < 8; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  // Reference mtime: req_valid is high at exactly one rising edge per bench access (the accepting one).
  always @(posedge clk) begin
    if (!rst) begin
      m_mtime <= '0;
      m_presc <= 0;
    end else if (req_valid && req_wen && req_addr[15:3] == 13'h17FF) begin
      m_mtime <= merge(m_mtime, req_wdata, req_wstrb);
      m_presc <= 0;
    end else begin
`ifdef YSYX_22040729_CLINT_PRESCALE_EN
      if (m_presc == TD - 1) begin
        m_mtime <= m_mtime + 64'd1;
        m_presc <= 0;
      end else begin
        m_presc <= m_presc + 1;
      end
`else
      m_mtime <= m_mtime + 64'd1;
`endif
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One full access: expectation pushed when driven, popped at the response handshake.
  task automatic bus(input logic wen, input logic [15:0] addr, input logic [DW-1:0] wdata,
                     input logic [7:0] wstrb, input logic [DW-1:0] exp_rd, input logic exp_err,
                     input bit model_rd, input int hold);
    logic [DW:0] exp;
    int n;
    @(negedge clk);
    if (model_rd) exp_rd = m_mtime;
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    sb_q.push_back({exp_err, exp_rd});
    check("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    @(negedge clk);
    post_tirp = tirp_o;
    post_sirp = sirp_o;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < hold; i++) begin
      check("hold_req_ready", 64'(req_ready), 64'd0);
      check("hold_rdata", rsp_rdata, exp_rd);
      check("hold_err", 64'(rsp_err), 64'(exp_err));
      @(negedge clk);
      check("hold_valid", 64'(rsp_valid), 64'd1);
    end
    rsp_ready = 1'b1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      exp = sb_q.pop_front();
      check("rsp_rdata", rsp_rdata, exp[DW-1:0]);
      check("rsp_err", 64'(rsp_err), 64'(exp[DW]));
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    rsp_ready = 1'b0;
    post_tirp = 1'b0;
    post_sirp = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_tirp", 64'(tirp_o), 64'd0);
    check("rst_sirp", 64'(sirp_o), 64'd0);
    rst = 1'b1;

`ifndef YSYX_22040729_CLINT_PRESCALE_EN
    // Four ticks after release, the fifth-edge read sees 4.
    repeat (4) @(posedge clk);
    bus(1'b0, 16'hBFF8, '0, 8'h00, 64'd4, 1'b0, 1'b0, 0);
    check("tirp_after_rst", 64'(tirp_o), 64'd0);

    bus(1'b1, 16'h4000, 64'h20, 8'hFF, '0, 1'b0, 1'b0, 0);
    bus(1'b1, 16'hBFF8, 64'h1E, 8'hFF, '0, 1'b0, 1'b0, 0);
    check("tirp_mtime_1e", 64'(post_tirp), 64'd0);
    @(negedge clk);
    check("tirp_mtime_1f", 64'(tirp_o), 64'd0);
    @(negedge clk);
    check("tirp_mtime_20", 64'(tirp_o), 64'd1);
    repeat (3) @(negedge clk);
    check("tirp_sticky", 64'(tirp_o), 64'd1);
    bus(1'b1, 16'h4000, 64'h100, 8'hFF, '0, 1'b0, 1'b0, 0);
    check("tirp_cmp_raised", 64'(post_tirp), 64'd0);

    bus(1'b1, 16'h4000, '1, 8'hFF, '0, 1'b0, 1'b0, 0);
    bus(1'b1, 16'hBFF8, '1, 8'hFF, '0, 1'b0, 1'b0, 0);
    check("tirp_mtime_max", 64'(post_tirp), 64'd1);
    check("tirp_after_wrap", 64'(tirp_o), 64'd0);
    bus(1'b0, 16'hBFF8, '0, 8'h00, '0, 1'b0, 1'b1, 0);
`else
    // Prescaled: write mtime=0, then the read accepted 12 edges later sees 3.
    bus(1'b1, 16'hBFF8, 64'h0, 8'hFF, '0, 1'b0, 1'b0, 0);
    repeat (11) @(posedge clk);
    bus(1'b0, 16'hBFF8, '0, 8'h00, 64'd3, 1'b0, 1'b0, 0);
    bus(1'b0, 16'hBFF8, '0, 8'h00, '0, 1'b0, 1'b1, 0);
`endif

    check("sirp_before", 64'(sirp_o), 64'd0);
    bus(1'b1, 16'h0000, 64'h1, 8'hFF, '0, 1'b0, 1'b0, 0);
    check("sirp_set", 64'(post_sirp), 64'd1);
    bus(1'b1, 16'h0000, 64'h0, 8'hFF, '0, 1'b0, 1'b0, 0);
    check("sirp_clr", 64'(post_sirp), 64'd0);
    bus(1'b1, 16'h0000, 64'hFFFF, 8'hFF, '0, 1'b0, 1'b0, 0);
    bus(1'b0, 16'h0000, '0, 8'h00, 64'h1, 1'b0, 1'b0, 0);
    check("sirp_ffff", 64'(sirp_o), 64'd1);

    bus(1'b1, 16'h4000, 64'h1111_2222_3333_4444, 8'hFF, '0, 1'b0, 1'b0, 0);
    bus(1'b1, 16'h4000, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, '0, 1'b0, 1'b0, 0);
    bus(1'b0, 16'h4005, '0, 8'h00, 64'h1111_2222_AAAA_AAAA, 1'b0, 1'b0, 0);
    bus(1'b1, 16'h0100, 64'hDEAD_BEEF, 8'hFF, '0, 1'b1, 1'b0, 0);
    bus(1'b0, 16'h4000, '0, 8'h00, 64'h1111_2222_AAAA_AAAA, 1'b0, 1'b0, 0);
    bus(1'b0, 16'h1000, '0, 8'h00, '0, 1'b1, 1'b0, 3);
    bus(1'b1, 16'hBFF8, 64'h5500, 8'h02, '0, 1'b0, 1'b0, 0);
    bus(1'b0, 16'hBFF8, '0, 8'h00, '0, 1'b0, 1'b1, 0);

    // Reset while a response is pending drops it.
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_addr  = 16'hBFF8;
    sb_q.push_back({1'b0, m_mtime});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 64'(rsp_valid), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd1);
    check("mid_rst_rdata", rsp_rdata, 64'd0);
    check("mid_rst_tirp", 64'(tirp_o), 64'd0);
    check("mid_rst_sirp", 64'(sirp_o), 64'd0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_addr  = 16'hBFF8;
    sb_q.push_back({1'b0, 64'd0});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b1;
    begin
      logic [DW:0] exp;
      exp = sb_q.pop_front();
      check("post_rst_mtime", rsp_rdata, exp[DW-1:0]);
      check("post_rst_err", 64'(rsp_err), 64'(exp[DW]));
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    bus(1'b0, 16'h4000, '0, 8'h00, '1, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
